// File: rtl/fact_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fact_pkg
//  Description : Shared widths, thresholds and accumulator-source encodings
//                for the iterative factorial engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package fact_pkg;

    // Default operand/counter and product widths
    localparam int FACT_N_W = 4;
    localparam int FACT_P_W = 32;

    // The loop keeps going while the counter is at least this value
    localparam int FACT_PROCEED_MIN = 2;

    // Accumulator source select encodings
    typedef enum logic {
        SEL_MUL = 1'b0,
        SEL_ONE = 1'b1
    } acc_sel_t;

    // True when the controller is re-initialising the accumulator
    function automatic logic is_init(input logic load, input logic sel);
        return load & (acc_sel_t'(sel) == SEL_ONE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fact_mul_ovf.sv
`default_nettype none
// ============================================================================
//  Module      : fact_mul_ovf
//  Description : Combinational P_W x N_W multiplier. Returns the product
//                truncated to P_W bits and a flag telling whether any of the
//                discarded high bits were set.
//  Revision    : 1.0 - initial release
// ============================================================================
module fact_mul_ovf #(
    parameter int P_W = 32,
    parameter int N_W = 4
) (
    input  logic [P_W-1:0] a,
    input  logic [N_W-1:0] b,
    output logic [P_W-1:0] prod,
    output logic           ovf
);

    localparam int c_full_w = P_W + N_W;

    logic [c_full_w-1:0] w_full;

    // Both operands are zero-extended so the multiply is exact at full width
    assign w_full = {{N_W{1'b0}}, a} * {{P_W{1'b0}}, b};
    assign prod   = w_full[P_W-1:0];
    assign ovf    = |w_full[c_full_w-1:P_W];

endmodule
`default_nettype wire

// File: rtl/fact_dp.sv
`default_nettype none
// ============================================================================
//  Module      : fact_dp
//  Description : Datapath of the iterative factorial engine: down-counter,
//                running-product accumulator, sticky overflow flag and a
//                captured-result register with a one-cycle valid strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module fact_dp
    import fact_pkg::*;
#(
    parameter int N_W = FACT_N_W,
    parameter int P_W = FACT_P_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N_W-1:0] n,
    input  logic           cnt_load,
    input  logic           cnt_en,
    input  logic           reg_sel,
    input  logic           reg_load,
    output logic           proceed,
    output logic [N_W-1:0] cnt,
    output logic [P_W-1:0] product,
    output logic           overflow,
    output logic [P_W-1:0] result,
    output logic           result_valid
);

    localparam logic [N_W-1:0] c_cnt_zero    = '0;
    localparam logic [N_W-1:0] c_cnt_one     = {{(N_W-1){1'b0}}, 1'b1};
    localparam logic [N_W-1:0] c_proceed_min = N_W'(FACT_PROCEED_MIN);
    localparam logic [P_W-1:0] c_prod_zero   = '0;
    localparam logic [P_W-1:0] c_prod_one    = {{(P_W-1){1'b0}}, 1'b1};

    logic [N_W-1:0] r_cnt;
    logic [P_W-1:0] r_product;
    logic           r_overflow;
    logic           r_armed;
    logic [P_W-1:0] r_result;
    logic           r_result_valid;

    logic [P_W-1:0] w_mul_prod;
    logic           w_mul_ovf;
    logic           w_proceed;
    logic           w_init;
    logic           w_mul_step;
    logic           w_capture;

    fact_mul_ovf #(
        .P_W (P_W),
        .N_W (N_W)
    ) u_mul (
        .a    (r_product),
        .b    (r_cnt),
        .prod (w_mul_prod),
        .ovf  (w_mul_ovf)
    );

    // Loop status depends only on the registered counter
    assign w_proceed  = (r_cnt >= c_proceed_min);

    // Init has priority over everything else in the accumulator/capture path
    assign w_init     = is_init(reg_load, reg_sel);

    // Multiply by zero is suppressed so that 0! stays at 1
    assign w_mul_step = reg_load & (acc_sel_t'(reg_sel) == SEL_MUL) & (r_cnt != c_cnt_zero);

    // Capture once per armed run, the first time the loop stops proceeding
    assign w_capture  = r_armed & ~w_proceed & ~w_init;

    // Down-counter: load from n, or decrement saturating at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= c_cnt_zero;
        end else if (cnt_en) begin
            if (cnt_load) begin
                r_cnt <= n;
            end else if (r_cnt != c_cnt_zero) begin
                r_cnt <= r_cnt - c_cnt_one;
            end
        end
    end

    // Accumulator and sticky overflow: init to 1, or fold in the counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_product  <= c_prod_one;
            r_overflow <= 1'b0;
        end else if (w_init) begin
            r_product  <= c_prod_one;
            r_overflow <= 1'b0;
        end else if (w_mul_step) begin
            r_product  <= w_mul_prod;
            r_overflow <= r_overflow | w_mul_ovf;
        end
    end

    // Armed flag: set by init, cleared by the capture it enables
    always_ff @(posedge clk) begin
        if (rst) begin
            r_armed <= 1'b0;
        end else if (w_init) begin
            r_armed <= 1'b1;
        end else if (w_capture) begin
            r_armed <= 1'b0;
        end
    end

    // Result register and its one-cycle strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result       <= c_prod_zero;
            r_result_valid <= 1'b0;
        end else begin
            r_result_valid <= w_capture;
            if (w_capture) begin
                r_result <= r_product;
            end
        end
    end

    assign proceed      = w_proceed;
    assign cnt          = r_cnt;
    assign product      = r_product;
    assign overflow     = r_overflow;
    assign result       = r_result;
    assign result_valid = r_result_valid;

endmodule
`default_nettype wire

// File: tb/tb_fact_dp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fact_dp
//  Description : Self-checking bench for fact_dp. Two instances (32-bit and
//                16-bit product) share one stimulus stream; expectations come
//                from plain factorial arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fact_dp;

    logic        clk;
    logic        rst;
    logic [3:0]  n_in;
    logic        cnt_load;
    logic        cnt_en;
    logic        reg_sel;
    logic        reg_load;

    logic        proceed_a, overflow_a, result_valid_a;
    logic [3:0]  cnt_a;
    logic [31:0] product_a, result_a;

    logic        proceed_b, overflow_b, result_valid_b;
    logic [3:0]  cnt_b;
    logic [15:0] product_b, result_b;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses_a = 0;
    int pulses_b = 0;

    fact_dp #(.N_W(4), .P_W(32)) dut_a (
        .clk(clk), .rst(rst), .n(n_in), .cnt_load(cnt_load), .cnt_en(cnt_en),
        .reg_sel(reg_sel), .reg_load(reg_load), .proceed(proceed_a), .cnt(cnt_a),
        .product(product_a), .overflow(overflow_a), .result(result_a),
        .result_valid(result_valid_a)
    );

    fact_dp #(.N_W(4), .P_W(16)) dut_b (
        .clk(clk), .rst(rst), .n(n_in), .cnt_load(cnt_load), .cnt_en(cnt_en),
        .reg_sel(reg_sel), .reg_load(reg_load), .proceed(proceed_b), .cnt(cnt_b),
        .product(product_b), .overflow(overflow_b), .result(result_b),
        .result_valid(result_valid_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string tag, input longint unsigned obs, input longint unsigned exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Product of the integers c+1 .. nv (empty product = 1)
    function automatic longint unsigned falling(input int nv, input int c);
        longint unsigned p = 1;
        for (int j = c + 1; j <= nv; j++) p = p * longint'(j);
        return p;
    endfunction

    function automatic longint unsigned mask(input longint unsigned v, input int pw);
        return v & ((64'd1 << pw) - 64'd1);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (result_valid_a) pulses_a++;
        if (result_valid_b) pulses_b++;
    endtask

    task automatic drv(input bit en, input bit ld, input bit rl, input bit rs);
        cnt_en = en; cnt_load = ld; reg_load = rl; reg_sel = rs;
    endtask

    task automatic do_idle(); drv(0, 0, 0, 0); endtask
    task automatic do_init(input int nv); n_in = 4'(nv); drv(1, 1, 1, 1); endtask
    task automatic do_mul();  drv(1, 0, 1, 0); endtask

    // Full run under a one-decrement-per-cycle controller with optional stalls
    task automatic run_fact(input int nv, input int stall_pct);
        int m_cnt;
        int pre;
        bit done;
        longint unsigned f;
        pulses_a = 0;
        pulses_b = 0;
        do_init(nv);
        step();
        m_cnt = nv;
        check("load_cnt", cnt_a, longint'(nv));
        check("init_prod", product_a, 1);
        check("init_ovf_b", overflow_b, 0);
        check("init_valid", result_valid_a, 0);
        done = 0;
        for (int k = 0; k < 400 && !done; k++) begin
            pre = m_cnt;
            if (int'($urandom_range(99)) < stall_pct) begin
                do_idle();
            end else if (m_cnt > 1) begin
                do_mul();
                m_cnt--;
            end else begin
                do_idle();
            end
            step();
            check("cnt", cnt_a, longint'(m_cnt));
            check("proceed", proceed_a, (m_cnt > 1) ? 1 : 0);
            check("prod_a", product_a, mask(falling(nv, m_cnt), 32));
            check("prod_b", product_b, mask(falling(nv, m_cnt), 16));
            check("valid_a", result_valid_a, (pre <= 1) ? 1 : 0);
            check("valid_b", result_valid_b, (pre <= 1) ? 1 : 0);
            if (pre <= 1) done = 1;
        end
        f = falling(nv, 0);
        check("result_a", result_a, mask(f, 32));
        check("ovf_a", overflow_a, ((f >> 32) != 0) ? 1 : 0);
        check("result_b", result_b, mask(f, 16));
        check("ovf_b", overflow_b, ((f >> 16) != 0) ? 1 : 0);
        do_idle();
        step();
        check("valid_after", result_valid_a, 0);
        check("pulses_a", longint'(pulses_a), 1);
        check("pulses_b", longint'(pulses_b), 1);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        rst = 1'b1;
        n_in = '0;
        do_idle();
        step();
        step();
        check("rst_cnt", cnt_a, 0);
        check("rst_proceed", proceed_a, 0);
        check("rst_prod", product_a, 1);
        check("rst_ovf", overflow_a, 0);
        check("rst_result", result_a, 0);
        check("rst_valid", result_valid_a, 0);
        rst = 1'b0;
        pulses_a = 0;
        repeat (3) step();
        check("no_spurious_valid", longint'(pulses_a), 0);

        // Basic run, then the 0! and 1! corner cases
        run_fact(5, 0);
        check("fact5", result_a, 120);
        run_fact(0, 0);
        run_fact(1, 0);

        // 9! overflows the 16-bit instance only; a fresh init clears it
        run_fact(9, 0);
        check("fact9_b", result_b, 35200);
        check("fact9_b_ovf", overflow_b, 1);
        do_init(2);
        step();
        check("ovf_cleared_b", overflow_b, 0);
        check("result_kept_b", result_b, 35200);
        do_idle();
        repeat (3) step();

        // Stall mid-run: counter and product hold with cnt_en/reg_load low
        do_init(6);
        step();
        do_mul(); step();
        do_mul(); step();
        check("pre_stall_cnt", cnt_a, 4);
        for (int s = 0; s < 3; s++) begin
            do_idle();
            step();
            check("stall_cnt", cnt_a, 4);
            check("stall_prod", product_a, 30);
        end
        while (cnt_a > 1 && n_checks < 5000) begin
            do_mul();
            step();
        end
        do_idle();
        step();
        check("stall_result", result_a, 720);
        check("stall_valid", result_valid_a, 1);

        // Decrementing and multiplying at the bottom: counter sticks at 0
        pulses_a = 0;
        for (int s = 0; s < 3; s++) begin
            do_mul();
            step();
            check("sat_cnt", cnt_a, 0);
            check("sat_proceed", proceed_a, 0);
            check("sat_prod", product_a, 720);
        end
        check("sat_no_valid", longint'(pulses_a), 0);

        // Reset in the middle of an n=5 run at cnt=3
        do_init(5);
        step();
        do_mul(); step();
        do_mul(); step();
        check("mid_cnt", cnt_a, 3);
        pulses_a = 0;
        rst = 1'b1;
        do_mul();
        step();
        rst = 1'b0;
        check("midrst_cnt", cnt_a, 0);
        check("midrst_prod", product_a, 1);
        check("midrst_result", result_a, 0);
        do_idle();
        repeat (8) step();
        check("midrst_no_valid", longint'(pulses_a), 0);

        // Init on the completion edge suppresses the capture
        run_fact(3, 0);
        do_init(3);
        step();
        do_mul(); step();
        do_mul(); step();
        check("conf_proceed", proceed_a, 0);
        pulses_a = 0;
        drv(0, 0, 1, 1);
        step();
        check("conf_valid", result_valid_a, 0);
        check("conf_prod", product_a, 1);
        check("conf_result", result_a, 6);
        run_fact(4, 0);
        check("after_conf", result_a, 24);

        // Random operands with random controller stalls
        for (int r = 0; r < 20; r++) begin
            run_fact(int'($urandom_range(15)), 25);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
